// File: rtl/fetch_decode_buffer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_decode_buffer_if : fetch push / decode pop handshake bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_decode_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_instr;
  logic [XLEN-1:0]          in_pc;
  logic [XLEN-1:0]          in_pc4;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_instr;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_pc4;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc4, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc4, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_decode_buffer : DEPTH-entry IF/ID FIFO, presents a NOP bubble when empty.
// Optional macro FDB_PERF_EN adds stall_cycles / bubble ports.        Rev 1.0
// ----------------------------------------------------------------------------
module fetch_decode_buffer #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_decode_buffer_if.slave bus
`ifdef FDB_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic                 bubble
`endif
);
  localparam int                 C_PTR_W = $clog2(DEPTH);
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(DEPTH);

  logic [XLEN-1:0]    instr_q [DEPTH];
  logic [XLEN-1:0]    pc_q    [DEPTH];
  logic [XLEN-1:0]    pc4_q   [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;

  // in_ready depends only on registered occupancy, never on out_ready.
  always_comb begin
    in_ready  = (count_q != C_FULL);
    out_valid = (count_q != '0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      if (push && !pop)      count_d = count_q + C_CNT_W'(1);
      else if (!push && pop) count_d = count_q - C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !bus.flush && !rst) begin
      instr_q[wr_ptr_q] <= bus.in_instr;
      pc_q[wr_ptr_q]    <= bus.in_pc;
      pc4_q[wr_ptr_q]   <= bus.in_pc4;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.out_instr = out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign bus.out_pc    = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign bus.out_pc4   = out_valid ? pc4_q[rd_ptr_q]   : '0;

`ifdef FDB_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Counts decode stalls against a valid head; survives flush, saturates.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (out_valid && !bus.out_ready && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble       = !out_valid;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_decode_buffer : directed checks on DEPTH=2 and DEPTH=4 instances. Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_decode_buffer;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_decode_buffer_if #(.XLEN(32), .DEPTH(2)) bus2 ();
  fetch_decode_buffer_if #(.XLEN(32), .DEPTH(4)) bus4 ();

`ifdef FDB_PERF_EN
  logic [31:0] stall2, stall4;
  logic        bubble2, bubble4;
`endif

  fetch_decode_buffer #(.XLEN(32), .DEPTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
`ifdef FDB_PERF_EN
    ,
    .stall_cycles (stall2),
    .bubble       (bubble2)
`endif
  );

  fetch_decode_buffer #(.XLEN(32), .DEPTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
`ifdef FDB_PERF_EN
    ,
    .stall_cycles (stall4),
    .bubble       (bubble4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive2(input logic v, input logic [31:0] pc);
    bus2.in_valid = v;
    bus2.in_pc    = pc;
    bus2.in_pc4   = pc + 32'd4;
    bus2.in_instr = instr_of(pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] pc;
    int          exp_cnt;
    int          sent;
    int          rcvd;
    int          cyc;
    logic        rdy;
    logic        do_push;
    logic        do_pop;

    drive2(1'b0, 32'h0);
    bus2.flush = 1'b0; bus2.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_pc = '0; bus4.in_pc4 = '0; bus4.in_instr = '0;
    bus4.flush = 1'b0; bus4.out_ready = 1'b0;

    // reset then idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_count",     bus2.count,     0);
    check("rst_out_valid", bus2.out_valid, 0);
    check("rst_in_ready",  bus2.in_ready,  1);
    check("rst_out_instr", bus2.out_instr, C_NOP);
    check("rst_out_pc",    bus2.out_pc,    0);
    check("rst_out_pc4",   bus2.out_pc4,   0);

    // streaming, one push and one pop per cycle
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive2(1'b1, 32'(4 * i));
      step();
      check("strm_valid", bus2.out_valid, 1);
      check("strm_pc",    bus2.out_pc,    4 * i);
      check("strm_pc4",   bus2.out_pc4,   4 * i + 4);
      check("strm_instr", bus2.out_instr, instr_of(32'(4 * i)));
      check("strm_count", bus2.count,     1);
    end
    drive2(1'b0, 32'h0);
    step();
    check("strm_drain_count", bus2.count,     0);
    check("strm_drain_instr", bus2.out_instr, C_NOP);

    // stall and fill; fetch holds 0x108 while in_ready is low
    bus2.out_ready = 1'b0;
    drive2(1'b1, 32'h100); step();
    check("fill1_count", bus2.count,  1);
    check("fill1_pc",    bus2.out_pc, 32'h100);
    drive2(1'b1, 32'h104); step();
    check("fill2_count",    bus2.count,    2);
    check("fill2_in_ready", bus2.in_ready, 0);
    drive2(1'b1, 32'h108); step();
    check("full_hold_count",    bus2.count,    2);
    check("full_hold_in_ready", bus2.in_ready, 0);
    check("full_hold_pc",       bus2.out_pc,   32'h100);
    bus2.out_ready = 1'b1;
    step();
    check("rel1_pc",       bus2.out_pc,   32'h104);
    check("rel1_count",    bus2.count,    1);
    check("rel1_in_ready", bus2.in_ready, 1);
    step();
    check("rel2_pc",    bus2.out_pc,  32'h108);
    check("rel2_pc4",   bus2.out_pc4, 32'h10C);
    check("rel2_count", bus2.count,   1);
    drive2(1'b0, 32'h0); step();
    check("rel3_count", bus2.count,     0);
    check("rel3_valid", bus2.out_valid, 0);

    // flush while full with a concurrent push attempt
    bus2.out_ready = 1'b0;
    drive2(1'b1, 32'h300); step();
    drive2(1'b1, 32'h304); step();
    check("pre_flush_count", bus2.count, 2);
    drive2(1'b1, 32'h200);
    bus2.flush = 1'b1;
    step();
    bus2.flush = 1'b0;
    drive2(1'b0, 32'h0);
    check("flush_count",    bus2.count,     0);
    check("flush_valid",    bus2.out_valid, 0);
    check("flush_in_ready", bus2.in_ready,  1);
    check("flush_instr",    bus2.out_instr, C_NOP);
    check("flush_pc",       bus2.out_pc,    0);
    step();
    check("flush_idle_valid", bus2.out_valid, 0);

    // flush at count 1 with push and pop both qualifying
    drive2(1'b1, 32'h500); step();
    check("pre_flush1_count", bus2.count, 1);
    drive2(1'b1, 32'h204);
    bus2.flush = 1'b1;
    bus2.out_ready = 1'b1;
    step();
    bus2.flush = 1'b0;
    drive2(1'b0, 32'h0);
    check("flush1_count", bus2.count,     0);
    check("flush1_valid", bus2.out_valid, 0);
    drive2(1'b1, 32'h600); step();
    check("post_flush_pc", bus2.out_pc, 32'h600);
    drive2(1'b0, 32'h0); step();

    // reset asserted mid-stream
    bus2.out_ready = 1'b0;
    drive2(1'b1, 32'h700); step();
    drive2(1'b1, 32'h704); step();
    check("pre_rst_count", bus2.count, 2);
    rst = 1'b1;
    drive2(1'b1, 32'h708);
    bus2.out_ready = 1'b1;
    step();
    rst = 1'b0;
    drive2(1'b0, 32'h0);
    check("mid_rst_count",    bus2.count,     0);
    check("mid_rst_valid",    bus2.out_valid, 0);
    check("mid_rst_pc",       bus2.out_pc,    0);
    check("mid_rst_in_ready", bus2.in_ready,  1);

`ifdef FDB_PERF_EN
    check("perf_rst_stall", stall2, 0);
    check("perf_rst_bubble", bubble2, 1);
    bus2.out_ready = 1'b0;
    drive2(1'b1, 32'h800); step();
    drive2(1'b0, 32'h0);
    check("perf_head_stall",  stall2,  0);
    check("perf_head_bubble", bubble2, 0);
    repeat (5) step();
    check("perf_stall5", stall2, 5);
    bus2.flush = 1'b1;
    bus2.out_ready = 1'b1;
    step();
    bus2.flush = 1'b0;
    check("perf_flush_stall",  stall2,  5);
    check("perf_flush_bubble", bubble2, 1);
    step();
    check("perf_idle_stall", stall2, 5);
    rst = 1'b1; step(); rst = 1'b0;
    check("perf_clear_stall", stall2, 0);
`endif

    // DEPTH=4 pointer wrap with a model scoreboard
    exp_cnt = 0; sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 200) begin
      check("wrap_in_ready", bus4.in_ready, (exp_cnt != 4));
      check("wrap_count",    bus4.count,    exp_cnt);
      if (exp_cnt > 0) check("wrap_out_pc", bus4.out_pc, q[0]);
      else             check("wrap_bubble", bus4.out_instr, C_NOP);
      rdy = (cyc < 6) ? 1'b0 : ($urandom_range(0, 1) == 1);
      pc  = 32'h400 + 32'(4 * sent);
      bus4.out_ready = rdy;
      bus4.in_valid  = (sent < 10);
      bus4.in_pc     = pc;
      bus4.in_pc4    = pc + 32'd4;
      bus4.in_instr  = instr_of(pc);
      do_push = (sent < 10) && (exp_cnt != 4);
      do_pop  = (exp_cnt != 0) && rdy;
      if (do_pop) begin
        void'(q.pop_front());
        rcvd++;
        exp_cnt--;
      end
      if (do_push) begin
        q.push_back(pc);
        sent++;
        exp_cnt++;
      end
      step();
      cyc++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    check("wrap_all_popped", rcvd, 10);
    check("wrap_end_count",  bus4.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
